// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule constants, state encoding and parameter checks.
package sm4_pkg;

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

   // Byte 0 of the table is the first (leftmost) byte of the concatenation.
   localparam logic [0:255][7:0] SBOX = {
      128'hd690e9fecce13db716b614c228fb2c05,
      128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62,
      128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8,
      128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887,
      128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1,
      128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f,
      128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8,
      128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684,
      128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   // CK[i] byte j = (4i+j)*7 mod 256, byte 0 in the most significant position.
   function automatic logic [31:0] ck_word(input logic [4:0] i);
      logic [31:0] w;
      w = '0;
      for (int j = 0; j < 4; j++)
         w[31-8*j -: 8] = 8'((int'(i) * 4 + j) * 7);
      return w;
   endfunction

   function automatic bit rpc_legal(input int r);
      return (r == 1) || (r == 2) || (r == 4) || (r == 8);
   endfunction

endpackage

// File: rtl/sm4_key_exp_one_round.sv
// One key-schedule round: consumes the K window, emits one round key and the shifted window.
module sm4_key_exp_one_round (
   input  logic [127:0] win,
   input  logic [31:0]  ck,
   output logic [31:0]  rk,
   output logic [127:0] wout
);

   logic [31:0] x;
   logic [31:0] b;
   logic [31:0] t;

   assign x = win[95:64] ^ win[63:32] ^ win[31:0] ^ ck;

   for (genvar j = 0; j < 4; j++) begin : g_sbox
      sm4_sbox u_sbox (
         .din  (x[8*j +: 8]),
         .dout (b[8*j +: 8])
      );
   end

   // Key-schedule linear layer: rotations by 13 and 23.
   assign t    = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
   assign rk   = win[127:96] ^ t;
   assign wout = {win[95:0], rk};

endmodule

// File: rtl/sm4_sbox.sv
// SM4 byte substitution, purely combinational.
module sm4_sbox
   import sm4_pkg::*;
(
   input  logic [7:0] din,
   output logic [7:0] dout
);

   assign dout = SBOX[din];

endmodule

// File: rtl/sm4_key_exp_iter.sv
// Iterative SM4 key expansion into a 32-entry round-key store, RPC rounds per clock.
//
// state  | meaning
// IDLE   | no key loaded since reset, ready for a key
// EXPAND | computing RPC round keys per cycle into the store
// DONE   | all 32 round keys readable, ready for a new key
module sm4_key_exp_iter
   import sm4_pkg::*;
#(
   parameter int RPC         = 1,
   parameter int DEC_DEFAULT = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key_in,
   output logic         keys_valid,
   output logic         busy,
   input  logic [4:0]   rd_idx,
   input  logic         rd_dec,
   output logic [31:0]  rd_rkey
);

   if (!rpc_legal(RPC)) begin : g_bad_rpc
      $error("sm4_key_exp_iter: RPC must be 1, 2, 4 or 8");
   end

   logic [1:0]   rst_sync;
   logic         rst_int_n;
   state_t       state;
   logic [4:0]   cnt;
   logic [127:0] kwin;
   logic [127:0] win [RPC+1];
   logic [31:0]  rk  [RPC];
   logic [31:0]  store [32];
   logic         accept;
   logic         dec_eff;

   // Assert asynchronously, release on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_int_n = rst_sync[1];

   assign win[0] = kwin;

   for (genvar g = 0; g < RPC; g++) begin : g_round
      logic [31:0] ck_g;
      assign ck_g = ck_word(cnt + 5'(g));
      sm4_key_exp_one_round u_round (
         .win  (win[g]),
         .ck   (ck_g),
         .rk   (rk[g]),
         .wout (win[g+1])
      );
   end

   assign accept = key_valid & key_ready;

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state      <= IDLE;
         key_ready  <= 1'b1;
         keys_valid <= 1'b0;
         busy       <= 1'b0;
         cnt        <= '0;
         kwin       <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state      <= EXPAND;
                  kwin       <= key_in ^ FK;
                  cnt        <= '0;
                  key_ready  <= 1'b0;
                  keys_valid <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            EXPAND: begin
               kwin <= win[RPC];
               cnt  <= cnt + 5'(RPC);
               if (cnt == 5'(32 - RPC)) begin
                  state      <= DONE;
                  key_ready  <= 1'b1;
                  keys_valid <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Key store is deliberately left unreset; keys_valid qualifies its contents.
   always_ff @(posedge clk) begin
      if (state == EXPAND) begin
         for (int g = 0; g < RPC; g++)
            store[cnt + 5'(g)] <= rk[g];
      end
   end

   assign dec_eff = rd_dec ^ (DEC_DEFAULT != 0);
   assign rd_rkey = store[dec_eff ? ~rd_idx : rd_idx];

endmodule

// File: tb/tb_sm4_key_exp_iter.sv
// Scoreboard bench for sm4_key_exp_iter: four instances (RPC 1,2,4,8) on shared stimulus.
module tb_sm4_key_exp_iter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         key_valid = 1'b0;
   logic [127:0] key_in = '0;
   logic [4:0]   rd_idx = '0;
   logic         rd_dec = 1'b0;
   logic [3:0]   key_ready;
   logic [3:0]   keys_valid;
   logic [3:0]   busy;
   logic [31:0]  rd_rkey [4];

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] sb_q [$];

   localparam logic [127:0] KEY_STD = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
   localparam logic [127:0] TB_FK   = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
   localparam logic [0:255][7:0] TB_SB = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   always #50 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sm4_key_exp_iter #(.RPC(1 << g), .DEC_DEFAULT(0)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .key_valid  (key_valid),
         .key_ready  (key_ready[g]),
         .key_in     (key_in),
         .keys_valid (keys_valid[g]),
         .busy       (busy[g]),
         .rd_idx     (rd_idx),
         .rd_dec     (rd_dec),
         .rd_rkey    (rd_rkey[g])
      );
   end

   function automatic logic [31:0] model_tp(input logic [31:0] x);
      logic [31:0] b;
      b = {TB_SB[x[31:24]], TB_SB[x[23:16]], TB_SB[x[15:8]], TB_SB[x[7:0]]};
      return b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
   endfunction

   function automatic void push_expected(input logic [127:0] mk);
      logic [31:0] k [36];
      logic [31:0] ck;
      logic [127:0] s;
      s = mk ^ TB_FK;
      for (int i = 0; i < 4; i++) k[i] = s[127-32*i -: 32];
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4*i + j) * 7);
         k[i+4] = k[i] ^ model_tp(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
         sb_q.push_back(k[i+4]);
      end
   endfunction

   task automatic accept(input logic [127:0] key);
      @(negedge clk);
      key_in    = key;
      key_valid = 1'b1;
      push_expected(key);
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      while (!keys_valid[0] && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int g = 0; g < 4; g++) begin
         n_vec += 3;
         if (key_ready[g] !== 1'b1) begin n_err++; $display("FAIL reset_key_ready[%0d]: got %b expected 1", g, key_ready[g]); end
         if (keys_valid[g] !== 1'b0) begin n_err++; $display("FAIL reset_keys_valid[%0d]: got %b expected 0", g, keys_valid[g]); end
         if (busy[g] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b expected 0", g, busy[g]); end
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_known_vector;
      int n;
      logic [31:0] exp;
      accept(KEY_STD);
      n_vec += 3;
      if (busy[0] !== 1'b1) begin n_err++; $display("FAIL kv_busy: got %b expected 1", busy[0]); end
      if (key_ready[0] !== 1'b0) begin n_err++; $display("FAIL kv_key_ready: got %b expected 0", key_ready[0]); end
      if (keys_valid[0] !== 1'b0) begin n_err++; $display("FAIL kv_keys_valid: got %b expected 0", keys_valid[0]); end
      wait_valid(40, n);
      n_vec++;
      if (n !== 32) begin n_err++; $display("FAIL kv_latency: got %0d expected 32", n); end
      rd_dec = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rd_idx = 5'(i);
         #1;
         exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
         n_vec++;
         if (rd_rkey[0] !== exp) begin n_err++; $display("FAIL kv_rk[%0d]: got %h expected %h", i, rd_rkey[0], exp); end
      end
      @(negedge clk);
      rd_idx = 5'd0; #1;
      n_vec++;
      if (rd_rkey[0] !== 32'hF12186F9) begin n_err++; $display("FAIL kv_rk0_const: got %h expected F12186F9", rd_rkey[0]); end
      rd_idx = 5'd31; #1;
      n_vec++;
      if (rd_rkey[0] !== 32'h9124A012) begin n_err++; $display("FAIL kv_rk31_const: got %h expected 9124A012", rd_rkey[0]); end
      rd_idx = 5'd0; rd_dec = 1'b1; #1;
      n_vec++;
      if (rd_rkey[0] !== 32'h9124A012) begin n_err++; $display("FAIL kv_dec0: got %h expected 9124A012", rd_rkey[0]); end
      rd_dec = 1'b0;
      n_vec += 2;
      if (keys_valid[0] !== 1'b1) begin n_err++; $display("FAIL kv_hold_valid: got %b expected 1", keys_valid[0]); end
      if (busy[0] !== 1'b0) begin n_err++; $display("FAIL kv_done_busy: got %b expected 0", busy[0]); end
   endtask

   task automatic test_rpc_variants;
      int lat [4];
      logic [31:0] exp;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      sb_q.delete();
      accept(KEY_STD);
      for (int g = 0; g < 4; g++) begin
         lat[g] = -1;
         n_vec += 2;
         if (busy[g] !== 1'b1) begin n_err++; $display("FAIL rpc_busy[%0d]: got %b expected 1", g, busy[g]); end
         if (key_ready[g] !== 1'b0) begin n_err++; $display("FAIL rpc_key_ready[%0d]: got %b expected 0", g, key_ready[g]); end
      end
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         for (int g = 0; g < 4; g++)
            if (lat[g] < 0 && keys_valid[g] === 1'b1) lat[g] = n;
      end
      for (int g = 0; g < 4; g++) begin
         n_vec++;
         if (lat[g] !== (32 >> g)) begin n_err++; $display("FAIL rpc_latency[RPC=%0d]: got %0d expected %0d", 1 << g, lat[g], 32 >> g); end
      end
      for (int i = 0; i < 32; i++) begin
         rd_idx = 5'(i);
         #1;
         exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
         for (int g = 0; g < 4; g++) begin
            n_vec++;
            if (rd_rkey[g] !== exp) begin n_err++; $display("FAIL rpc_rk[RPC=%0d][%0d]: got %h expected %h", 1 << g, i, rd_rkey[g], exp); end
         end
      end
      @(negedge clk);
      rd_idx = 5'd0; rd_dec = 1'b1; #1;
      for (int g = 0; g < 4; g++) begin
         n_vec++;
         if (rd_rkey[g] !== 32'h9124A012) begin n_err++; $display("FAIL rpc_dec0[RPC=%0d]: got %h expected 9124A012", 1 << g, rd_rkey[g]); end
      end
      rd_dec = 1'b0;
   endtask

   task automatic test_ignore_mid_expand;
      int n;
      logic [31:0] exp;
      accept(KEY_STD);
      n_vec++;
      if (keys_valid[0] !== 1'b0) begin n_err++; $display("FAIL ign_valid_drop: got %b expected 0", keys_valid[0]); end
      repeat (9) @(negedge clk);
      key_in    = 128'hDEADBEEF_00112233_44556677_8899AABB;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      n_vec++;
      if (busy[0] !== 1'b1) begin n_err++; $display("FAIL ign_busy: got %b expected 1", busy[0]); end
      wait_valid(40, n);
      n_vec++;
      if (n !== 22) begin n_err++; $display("FAIL ign_latency: got %0d expected 22", n); end
      for (int i = 0; i < 32; i++) begin
         rd_idx = 5'(i);
         #1;
         exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
         n_vec++;
         if (rd_rkey[0] !== exp) begin n_err++; $display("FAIL ign_rk[%0d]: got %h expected %h", i, rd_rkey[0], exp); end
      end
      @(negedge clk);
   endtask

   task automatic test_relatch;
      int n;
      logic [31:0] exp;
      accept({$urandom, $urandom, $urandom, $urandom});
      n_vec++;
      if (keys_valid[0] !== 1'b0) begin n_err++; $display("FAIL relatch_valid_drop: got %b expected 0", keys_valid[0]); end
      wait_valid(40, n);
      n_vec++;
      if (n !== 32) begin n_err++; $display("FAIL relatch_latency: got %0d expected 32", n); end
      for (int i = 0; i < 32; i++) begin
         rd_idx = 5'(i);
         #1;
         exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
         n_vec++;
         if (rd_rkey[0] !== exp) begin n_err++; $display("FAIL relatch_rk[%0d]: got %h expected %h", i, rd_rkey[0], exp); end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_expand;
      int n;
      logic [31:0] exp;
      accept(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_vec += 3;
      if (key_ready[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_key_ready: got %b expected 1", key_ready[0]); end
      if (busy[0] !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy[0]); end
      if (keys_valid[0] !== 1'b0) begin n_err++; $display("FAIL rstmid_keys_valid: got %b expected 0", keys_valid[0]); end
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      accept({$urandom, $urandom, $urandom, $urandom});
      wait_valid(40, n);
      n_vec++;
      if (n !== 32) begin n_err++; $display("FAIL rstmid_latency: got %0d expected 32", n); end
      for (int i = 0; i < 32; i++) begin
         rd_idx = 5'(i);
         #1;
         exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
         n_vec++;
         if (rd_rkey[0] !== exp) begin n_err++; $display("FAIL rstmid_rk[%0d]: got %h expected %h", i, rd_rkey[0], exp); end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int n;
      logic [31:0] exp;
      @(negedge clk);
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      key_valid = 1'b1;
      push_expected(key_in);
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         n_vec += 2;
         if (keys_valid[0] !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop[%0d]: got %b expected 0", r, keys_valid[0]); end
         if (busy[0] !== 1'b1) begin n_err++; $display("FAIL b2b_busy[%0d]: got %b expected 1", r, busy[0]); end
         wait_valid(40, n);
         n_vec++;
         if (n !== 32) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d expected 32", r, n); end
         for (int i = 0; i < 32; i++) begin
            rd_idx = 5'(i);
            #1;
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
            n_vec++;
            if (rd_rkey[0] !== exp) begin n_err++; $display("FAIL b2b_rk[%0d][%0d]: got %h expected %h", r, i, rd_rkey[0], exp); end
         end
         if (r < 2) begin
            key_in = {$urandom, $urandom, $urandom, $urandom};
            push_expected(key_in);
         end else begin
            key_valid = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_known_vector;
      test_rpc_variants;
      test_ignore_mid_expand;
      test_relatch;
      test_reset_mid_expand;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
